// File: rtl/curve_lut_ram.sv
// curve_lut_ram: double-banked, runtime-programmable DW -> DW luminance curve.
// The video path reads the active bank while the host fills the shadow bank.
// A committed curve goes live at the next frame start (rising vsync), so a
// frame is never mapped by a half-written curve. Sync/enable and data share
// a fixed 2-cycle pipeline.
// Optional feature macro: CURVE_LUT_IDENTITY_INIT_EN -- after reset an INIT
// state writes entry[i] = i into both banks, one address per cycle.
//
// Host write port: lut_wr_en is a fire-and-forget strobe (one entry per cycle,
// no ready). Every strobe outside INIT is accepted into the shadow bank; lut_busy
// is status only and never back-pressures the host.
module curve_lut_ram #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          lut_wr_en,
    input  logic [DW-1:0] lut_wr_addr,
    input  logic [DW-1:0] lut_wr_data,
    input  logic          lut_commit,
    output logic          lut_busy,
    output logic          active_bank,
    input  logic          per_frame_vsync,
    input  logic          per_frame_href,
    input  logic          per_frame_clken,
    input  logic [DW-1:0] per_img_Y,
    output logic          post_frame_vsync,
    output logic          post_frame_href,
    output logic          post_frame_clken,
    output logic [DW-1:0] post_img_Y,
    output logic [1:0]    dbg_state
);

    localparam int DEPTH = 1 << DW;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_PENDING = 2'd2
    } state_t;

`ifdef CURVE_LUT_IDENTITY_INIT_EN
    localparam state_t RESET_STATE = ST_INIT;
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    state_t        state_q, state_d;
    logic          vsync_q, vsync_d;
    logic          active_bank_q, active_bank_d;
    logic          lut_valid_q, lut_valid_d;
    logic          fs;
    logic          swap;
    logic          init_wr;
    logic          init_done;

    // stage 1 (address register) and stage 2 (output register)
    logic          vs_s1_q, vs_s1_d;
    logic          hr_s1_q, hr_s1_d;
    logic          ck_s1_q, ck_s1_d;
    logic [DW-1:0] y_s1_q, y_s1_d;
    logic          sel_s1_q, sel_s1_d;
    logic          val_s1_q, val_s1_d;
    logic          vs_s2_q, vs_s2_d;
    logic          hr_s2_q, hr_s2_d;
    logic          ck_s2_q, ck_s2_d;
    logic [DW-1:0] y_s2_q, y_s2_d;
    logic [DW-1:0] rd_data;

    // table write port shared by host and INIT
    logic          wr0_en, wr1_en;
    logic [DW-1:0] wr_addr, wr_data;
    logic [DW-1:0] mem0_q [DEPTH];
    logic [DW-1:0] mem1_q [DEPTH];

`ifdef CURVE_LUT_IDENTITY_INIT_EN
    logic [DW-1:0] init_cnt_q, init_cnt_d;

    // INIT address counter: walks every entry once, then stops
    always_comb begin
        init_cnt_d = init_cnt_q;
        if (state_q == ST_INIT) begin
            init_cnt_d = init_cnt_q + 1'b1;
        end
    end

    // INIT address counter register; restarts from entry 0 on every reset
    always_ff @(posedge clk) begin
        if (rst) begin
            init_cnt_q <= '0;
        end else begin
            init_cnt_q <= init_cnt_d;
        end
    end

    assign init_done = (state_q == ST_INIT) && (init_cnt_q == {DW{1'b1}});
`else
    assign init_done = 1'b0;
`endif

    assign fs = per_frame_vsync & ~vsync_q;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: commit arms PENDING unless it coincides with a frame start
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:    if (init_done) state_d = ST_IDLE;
            ST_IDLE:    if (lut_commit && !fs) state_d = ST_PENDING;
            ST_PENDING: if (fs) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: busy flag, bank swap strobe, INIT write enable
    always_comb begin
        lut_busy = 1'b0;
        swap     = 1'b0;
        init_wr  = 1'b0;
        case (state_q)
            ST_INIT: begin
                lut_busy = 1'b1;
                init_wr  = 1'b1;
            end
            ST_IDLE:    swap = lut_commit & fs;
            ST_PENDING: begin
                lut_busy = 1'b1;
                swap     = fs;
            end
            default: ;
        endcase
    end

    // Bank/valid update and write-port steering (host targets the pre-swap shadow)
    always_comb begin
        vsync_d       = per_frame_vsync;
        active_bank_d = active_bank_q ^ swap;
        lut_valid_d   = lut_valid_q | swap | init_done;
        wr_data       = lut_wr_data;
        wr_addr       = lut_wr_addr;
        wr0_en        = 1'b0;
        wr1_en        = 1'b0;
        if (!rst) begin
            if (init_wr) begin
`ifdef CURVE_LUT_IDENTITY_INIT_EN
                wr_addr = init_cnt_q;
                wr_data = init_cnt_q;
`endif
                wr0_en  = 1'b1;
                wr1_en  = 1'b1;
            end else if (lut_wr_en) begin
                wr0_en  = active_bank_q;
                wr1_en  = ~active_bank_q;
            end
        end
    end

    // Control registers: previous vsync, active bank, curve-valid flag
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q       <= 1'b0;
            active_bank_q <= 1'b0;
            lut_valid_q   <= 1'b0;
        end else begin
            vsync_q       <= vsync_d;
            active_bank_q <= active_bank_d;
            lut_valid_q   <= lut_valid_d;
        end
    end

    // Table storage; not reset, contents persist until overwritten
    always_ff @(posedge clk) begin
        if (wr0_en) mem0_q[wr_addr] <= wr_data;
        if (wr1_en) mem1_q[wr_addr] <= wr_data;
    end

    // Pipeline next values: stage 1 samples the post-swap bank, stage 2 maps and gates
    always_comb begin
        vs_s1_d  = per_frame_vsync;
        hr_s1_d  = per_frame_href;
        ck_s1_d  = per_frame_clken;
        y_s1_d   = per_img_Y;
        sel_s1_d = active_bank_d;
        val_s1_d = lut_valid_d;
        rd_data  = sel_s1_q ? mem1_q[y_s1_q] : mem0_q[y_s1_q];
        vs_s2_d  = vs_s1_q;
        hr_s2_d  = hr_s1_q;
        ck_s2_d  = ck_s1_q;
        y_s2_d   = '0;
        if (ck_s1_q) begin
            y_s2_d = val_s1_q ? rd_data : y_s1_q;
        end
    end

    // Pipeline registers; reset flushes both stages to zero
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_s1_q  <= 1'b0;
            hr_s1_q  <= 1'b0;
            ck_s1_q  <= 1'b0;
            y_s1_q   <= '0;
            sel_s1_q <= 1'b0;
            val_s1_q <= 1'b0;
            vs_s2_q  <= 1'b0;
            hr_s2_q  <= 1'b0;
            ck_s2_q  <= 1'b0;
            y_s2_q   <= '0;
        end else begin
            vs_s1_q  <= vs_s1_d;
            hr_s1_q  <= hr_s1_d;
            ck_s1_q  <= ck_s1_d;
            y_s1_q   <= y_s1_d;
            sel_s1_q <= sel_s1_d;
            val_s1_q <= val_s1_d;
            vs_s2_q  <= vs_s2_d;
            hr_s2_q  <= hr_s2_d;
            ck_s2_q  <= ck_s2_d;
            y_s2_q   <= y_s2_d;
        end
    end

    assign active_bank      = active_bank_q;
    assign post_frame_vsync = vs_s2_q;
    assign post_frame_href  = hr_s2_q;
    assign post_frame_clken = ck_s2_q;
    assign post_img_Y       = y_s2_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_curve_lut_ram.sv
// tb_curve_lut_ram: randomized video and host traffic against a frame-level
// reference model of the double-banked curve (two arrays plus active/valid/
// pending flags). Expected outputs queue up and are popped 2 cycles later.
module tb_curve_lut_ram;

    localparam int DW = 8;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic          lut_wr_en;
    logic [DW-1:0] lut_wr_addr;
    logic [DW-1:0] lut_wr_data;
    logic          lut_commit;
    logic          lut_busy;
    logic          active_bank;
    logic          per_frame_vsync;
    logic          per_frame_href;
    logic          per_frame_clken;
    logic [DW-1:0] per_img_Y;
    logic          post_frame_vsync;
    logic          post_frame_href;
    logic          post_frame_clken;
    logic [DW-1:0] post_img_Y;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    curve_lut_ram #(.DW(DW)) dut (
        .clk              (clk),
        .rst              (rst),
        .lut_wr_en        (lut_wr_en),
        .lut_wr_addr      (lut_wr_addr),
        .lut_wr_data      (lut_wr_data),
        .lut_commit       (lut_commit),
        .lut_busy         (lut_busy),
        .active_bank      (active_bank),
        .per_frame_vsync  (per_frame_vsync),
        .per_frame_href   (per_frame_href),
        .per_frame_clken  (per_frame_clken),
        .per_img_Y        (per_img_Y),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_href  (post_frame_href),
        .post_frame_clken (post_frame_clken),
        .post_img_Y       (post_img_Y),
        .dbg_state        (dbg_state)
    );

    // ---------------- scoreboard / reference model ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [11:0] exp_q[$];          // {check_y, vsync, href, clken, Y}
    logic [15:0] wr_q[$];           // pending host writes {addr, data}
    bit          wr_force   = 1'b0; // issue the next queued write this cycle
    bit          commit_now = 1'b0; // pulse lut_commit this cycle
    logic [7:0]  m_bank [2][256];
    bit          m_known[2][256];
    bit          m_active, m_valid, m_pending, m_vs_prev;
    int          m_init_left;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_active  = 1'b0;
        m_valid   = 1'b0;
        m_pending = 1'b0;
        m_vs_prev = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 256; i++) m_known[b][i] = 1'b0;
`ifdef CURVE_LUT_IDENTITY_INIT_EN
        m_init_left = 256;
`else
        m_init_left = 0;
`endif
    endtask

    // One clock: drive host port, advance the model, check outputs after the edge
    task automatic cycle();
        bit          fs;
        bit          we;
        bit          chk;
        logic [7:0]  wa, wd, ye;
        logic [15:0] w;
        logic [11:0] e;
        we = 1'b0;
        wa = 8'($urandom);
        wd = 8'($urandom);
        if (!rst && wr_q.size() > 0 && (wr_force || $urandom_range(0, 3) != 0)) begin
            w  = wr_q.pop_front();
            we = 1'b1;
            wa = w[15:8];
            wd = w[7:0];
        end
        lut_wr_en   = we;
        lut_wr_addr = wa;
        lut_wr_data = wd;
        lut_commit  = commit_now;
        wr_force    = 1'b0;
        commit_now  = 1'b0;
        if (rst) begin
            model_reset();
            exp_q.push_back(12'h800);
            exp_q.push_back(12'h800);
        end else begin
            fs = per_frame_vsync && !m_vs_prev;
            m_vs_prev = per_frame_vsync;
            if (m_init_left > 0) begin
                m_init_left--;
                if (m_init_left == 0) begin
                    for (int b = 0; b < 2; b++)
                        for (int i = 0; i < 256; i++) begin
                            m_bank[b][i]  = 8'(i);
                            m_known[b][i] = 1'b1;
                        end
                    m_valid = 1'b1;
                end
            end else begin
                if (we) begin
                    m_bank[m_active ? 0 : 1][wa]  = wd;
                    m_known[m_active ? 0 : 1][wa] = 1'b1;
                end
                if (lut_commit) m_pending = 1'b1;
                if (m_pending && fs) begin
                    m_active  = !m_active;
                    m_valid   = 1'b1;
                    m_pending = 1'b0;
                end
            end
            chk = 1'b1;
            if (!per_frame_clken) ye = 8'h00;
            else if (!m_valid) ye = per_img_Y;
            else begin
                ye  = m_bank[m_active ? 1 : 0][per_img_Y];
                chk = m_known[m_active ? 1 : 0][per_img_Y];
            end
            exp_q.push_back({chk, per_frame_vsync, per_frame_href, per_frame_clken, ye});
        end
        @(posedge clk);
        #1;
        if (exp_q.size() == 2) begin
            e = exp_q.pop_front();
            check("post_vsync", post_frame_vsync, e[10]);
            check("post_href",  post_frame_href,  e[9]);
            check("post_clken", post_frame_clken, e[8]);
            if (e[11]) check("post_y", post_img_Y, e[7:0]);
        end
        check("lut_busy", lut_busy, (m_init_left > 0) || m_pending);
        check("active_bank", active_bank, m_active);
    endtask

    // ---------------- driver tasks ----------------
    task automatic pix(input bit vs, input bit hr, input bit ck, input logic [7:0] y);
        per_frame_vsync = vs;
        per_frame_href  = hr;
        per_frame_clken = ck;
        per_img_Y       = y;
        cycle();
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        commit_now = 1'b0;
        wr_q.delete();
        pix(0, 0, 0, 8'h00);
        pix(0, 0, 0, 8'h00);
        rst = 1'b0;
    endtask

    // Vertical blank; the rising-vsync cycle carries a live pixel
    task automatic vblank();
        pix(1, 1, 1, 8'($urandom));
        pix(1, 0, 0, 8'($urandom));
        pix(1, 0, 0, 8'($urandom));
        pix(0, 0, 0, 8'($urandom));
        pix(0, 0, 0, 8'($urandom));
    endtask

    task automatic line_rand(input int n);
        for (int i = 0; i < n; i++) pix(0, 1, $urandom_range(0, 3) != 0, 8'($urandom));
        pix(0, 0, 0, 8'h00);
    endtask

    task automatic drain_writes();
        int guard = 0;
        while (wr_q.size() > 0 && guard < 4000) begin
            pix(0, 1, $urandom_range(0, 1) == 1, 8'($urandom));
            guard++;
        end
    endtask

    // Single pixel with clken, then read its mapped value two edges later
    task automatic map_check(input string tag, input logic [7:0] y, input logic [7:0] exp);
        pix(0, 1, 1, y);
        pix(0, 1, 0, 8'h00);
        check(tag, post_img_Y, exp);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cnt;
        int s;
        rst = 1'b1;
        lut_wr_en = 1'b0; lut_wr_addr = '0; lut_wr_data = '0; lut_commit = 1'b0;
        per_frame_vsync = 1'b0; per_frame_href = 1'b0; per_frame_clken = 1'b0; per_img_Y = '0;
        model_reset();

        // reset state
        do_reset();
        check("rst_post_vsync", post_frame_vsync, 1'b0);
        check("rst_post_href",  post_frame_href,  1'b0);
        check("rst_post_clken", post_frame_clken, 1'b0);
        check("rst_post_y",     post_img_Y,       8'h00);
        check("rst_active_bank", active_bank,     1'b0);
`ifdef CURVE_LUT_IDENTITY_INIT_EN
        check("rst_busy", lut_busy, 1'b1);
        cnt = 0;
        while (lut_busy && cnt < 400) begin
            cnt++;
            pix(0, 1, 1, 8'($urandom));
        end
        check("init_busy_cycles", cnt, 256);
`else
        check("rst_busy", lut_busy, 1'b0);
`endif

        // ramp through the bypass/identity path, then random clken gaps
        vblank();
        for (int i = 0; i < 256; i++) pix(0, 1, 1, 8'(i));
        pix(0, 0, 0, 8'h00);
        line_rand(64);

        // inverted curve, committed mid-frame, live from the next frame start
        for (int i = 0; i < 256; i++) wr_q.push_back({8'(i), 8'(255 - i)});
        drain_writes();
        line_rand(20);
        commit_now = 1'b1;
        pix(0, 1, 1, 8'($urandom));
        check("busy_after_commit", lut_busy, 1'b1);
        line_rand(40);
        commit_now = 1'b1;
        pix(0, 1, 1, 8'($urandom));
        line_rand(20);
        check("bank_before_vsync", active_bank, 1'b0);
        vblank();
        check("bank_after_swap", active_bank, 1'b1);
        check("busy_after_swap", lut_busy, 1'b0);
        map_check("inv_map_10", 8'h10, 8'hEF);
        line_rand(64);

        // commit and write on the same cycle as the vsync rise
        for (int i = 0; i < 256; i++) wr_q.push_back({8'(i), 8'($urandom)});
        drain_writes();
        wr_q.push_back({8'h40, 8'h00});
        wr_force   = 1'b1;
        commit_now = 1'b1;
        vblank();
        check("same_cycle_bank", active_bank, 1'b0);
        check("same_cycle_busy", lut_busy, 1'b0);
        map_check("same_cycle_map_40", 8'h40, 8'h00);
        line_rand(40);

        // reset while PENDING mid-frame discards the swap
        for (int i = 0; i < 16; i++) wr_q.push_back({8'($urandom), 8'($urandom)});
        drain_writes();
        commit_now = 1'b1;
        pix(0, 1, 1, 8'($urandom));
        line_rand(10);
        check("pending_busy", lut_busy, 1'b1);
        pix(0, 1, 1, 8'($urandom));
        do_reset();
        check("midrst_post_clken", post_frame_clken, 1'b0);
        check("midrst_post_href",  post_frame_href,  1'b0);
        check("midrst_post_y",     post_img_Y,       8'h00);
        check("midrst_bank",       active_bank,      1'b0);
`ifdef CURVE_LUT_IDENTITY_INIT_EN
        wr_q.push_back({8'h20, 8'h55});
        wr_force = 1'b1;
        cnt = 0;
        while (lut_busy && cnt < 400) begin
            cnt++;
            pix(0, 1, 1, 8'($urandom));
        end
        check("init2_done", lut_busy, 1'b0);
`endif
        vblank();
        check("no_swap_after_rst", active_bank, 1'b0);
        map_check("bypass_80", 8'h80, 8'h80);
        line_rand(64);

        // S-curve into the shadow bank, swapped at the next frame start
        for (int i = 0; i < 256; i++) begin
            if (i < 128) s = (i * i) >> 7;
            else s = 255 - (((255 - i) * (255 - i)) >> 7);
`ifdef CURVE_LUT_IDENTITY_INIT_EN
            if (i != 8'h20) wr_q.push_back({8'(i), 8'(s)});
`else
            wr_q.push_back({8'(i), 8'(s)});
`endif
        end
        drain_writes();
        commit_now = 1'b1;
        pix(0, 1, 1, 8'($urandom));
        line_rand(30);
        map_check("s_before_swap_80", 8'h80, 8'h80);
        vblank();
        check("s_bank", active_bank, 1'b1);
        map_check("s_map_80", 8'h80, 8'h81);
`ifdef CURVE_LUT_IDENTITY_INIT_EN
        map_check("init_drop_20", 8'h20, 8'h20);
`endif
        line_rand(100);
        vblank();
        line_rand(50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
